// File: rtl/pc_step_controller.sv
`timescale 1ns/1ps
// pc_step_controller: decides when the single-cycle core's PC advances.
// Produces one-cycle pc_en pulses either at a fixed divided rate (run mode)
// or once per debounced step-button press (step mode). It freezes the PC
// on an ecall until the IO block acknowledges it.
module pc_step_controller #(
  parameter int RUN_DIV   = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             ecall,
  input  logic             ecall_ack,
  output logic             pc_en,
  output logic             ecall_hold,
  output logic             running,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_ECALL = 2'd3
  } state_t;

  localparam int               DIV_W   = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);
  localparam int               DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DB_CYCLES - 1);

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_pc_en;
  logic [CNT_W-1:0] r_step_count;
  logic             r_ack_prev;

  logic             r_sync1;
  logic             r_sync2;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_db_level;
  logic             r_db_prev;

  logic             w_step_req;
  logic             w_ack_rise;
  logic             w_ecall_take;

  // Debounced rising edge of the step button: one pulse per press.
  assign w_step_req   = r_db_level & ~r_db_prev;
  // The IO block signals completion with a rising edge on its ack level.
  assign w_ack_rise   = ecall_ack & ~r_ack_prev;
  // While pc_en is high the PC still points at the serviced ecall, so the
  // decoder's flag for it must not re-trap.
  assign w_ecall_take = ecall & ~r_pc_en;

  // Synchronize the raw button, then accept a new level only after it has
  // disagreed with the current one for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes the two-flop chain work.
      r_sync1   <= step_btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (r_sync2 != r_db_level) begin
        if (r_db_cnt == DB_MAX) begin
          r_db_level <= r_sync2;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        // Any bounce back to the accepted level restarts the count.
        r_db_cnt <= '0;
      end
    end
  end

  // Sequencer: halt > ecall > mode change > pulse generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_pc_en      <= 1'b0;
      r_step_count <= '0;
      r_ack_prev   <= 1'b0;
    end else begin
      // NOTE: defaulting pc_en low at the top of the block makes it a
      // one-cycle pulse; only the branches below that advance the PC raise it.
      r_pc_en    <= 1'b0;
      r_ack_prev <= ecall_ack;
      if (halt) begin
        r_state   <= S_IDLE;
        r_div_cnt <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state   <= run_mode ? S_RUN : S_STEP;
              r_div_cnt <= '0;
            end
          end
          S_RUN: begin
            if (w_ecall_take) begin
              r_state   <= S_ECALL;
              r_div_cnt <= '0;
            end else if (!run_mode) begin
              r_state   <= S_STEP;
              r_div_cnt <= '0;
            end else if (r_div_cnt == DIV_MAX) begin
              r_div_cnt    <= '0;
              r_pc_en      <= 1'b1;
              r_step_count <= r_step_count + CNT_W'(1);
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          S_STEP: begin
            if (w_ecall_take) begin
              r_state <= S_ECALL;
            end else if (run_mode) begin
              r_state   <= S_RUN;
              r_div_cnt <= '0;
            end else if (w_step_req) begin
              r_pc_en      <= 1'b1;
              r_step_count <= r_step_count + CNT_W'(1);
            end
          end
          S_ECALL: begin
            // Button presses arriving here are simply dropped.
            if (w_ack_rise) begin
              r_state      <= run_mode ? S_RUN : S_STEP;
              r_div_cnt    <= '0;
              r_pc_en      <= 1'b1;
              r_step_count <= r_step_count + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pc_en      = r_pc_en;
  assign state      = r_state;
  assign running    = (r_state == S_RUN);
  assign halted     = (r_state == S_IDLE);
  assign ecall_hold = (r_state == S_ECALL);
  assign step_count = r_step_count;

endmodule

// File: tb/tb_pc_step_controller.sv
`timescale 1ns/1ps
// Bench for pc_step_controller: a cycle-level reference model checked on
// every falling edge, plus directed scenarios with hand-derived values.
module tb_pc_step_controller;

  localparam int RUN_DIV   = 4;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 32;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_STEP  = 2;
  localparam int M_ECALL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic run_mode = 1'b0;
  logic step_btn = 1'b0;
  logic ecall = 1'b0;
  logic ecall_ack = 1'b0;

  logic             pc_en;
  logic             ecall_hold;
  logic             running;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_step_controller #(
    .RUN_DIV  (RUN_DIV),
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt      (halt),
    .run_mode  (run_mode),
    .step_btn  (step_btn),
    .ecall     (ecall),
    .ecall_ack (ecall_ack),
    .pc_en     (pc_en),
    .ecall_hold(ecall_hold),
    .running   (running),
    .halted    (halted),
    .state     (state),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_mode;
  int               m_age;        // cycles spent in RUN since entering it
  bit               m_pc_en;
  logic [CNT_W-1:0] m_count;
  bit               m_ack_prev;
  bit               m_s1, m_s2;
  bit               m_level;
  bit               m_step_req;
  bit               m_hist[DB_CYCLES];
  bit               m_pulse;
  bit               m_all_diff;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_age = 0; m_pc_en = 0; m_count = '0; m_ack_prev = 0;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_step_req = 0;
      for (int i = 0; i < DB_CYCLES; i++) m_hist[i] = 0;
    end else begin
      m_pulse = 0;
      if (halt) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (start) begin m_mode = run_mode ? M_RUN : M_STEP; m_age = 0; end
      end else if (m_mode == M_ECALL) begin
        if (ecall_ack && !m_ack_prev) begin
          m_mode = run_mode ? M_RUN : M_STEP; m_age = 0; m_pulse = 1;
        end
      end else if (ecall && !m_pc_en) begin
        m_mode = M_ECALL;
      end else if (m_mode == M_RUN && !run_mode) begin
        m_mode = M_STEP;
      end else if (m_mode == M_STEP && run_mode) begin
        m_mode = M_RUN; m_age = 0;
      end else if (m_mode == M_RUN) begin
        m_pulse = ((m_age + 1) % RUN_DIV) == 0;
        m_age++;
      end else begin
        m_pulse = m_step_req;
      end
      m_ack_prev = ecall_ack;
      m_pc_en = m_pulse;
      if (m_pulse) m_count = m_count + 1;
      // Debounce: accept the synchronized level once the last DB_CYCLES
      // samples all disagree with the currently accepted level.
      for (int i = 0; i < DB_CYCLES - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[DB_CYCLES-1] = m_s2;
      m_all_diff = 1;
      for (int i = 0; i < DB_CYCLES; i++) if (m_hist[i] == m_level) m_all_diff = 0;
      m_step_req = 0;
      if (m_all_diff) begin
        m_level = ~m_level;
        m_step_req = m_level;
      end
      m_s2 = m_s1;
      m_s1 = step_btn;
    end
  end

  // Continuous comparison against the model whenever out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_pc_en",      pc_en,      m_pc_en);
      check("cmp_state",      state,      m_mode);
      check("cmp_ecall_hold", ecall_hold, m_mode == M_ECALL);
      check("cmp_running",    running,    m_mode == M_RUN);
      check("cmp_halted",     halted,     m_mode == M_IDLE);
      check("cmp_step_count", step_count, m_count);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  int pulses;
  int first;

  initial begin
    cyc(2);
    check("rst_state",  state, 0);
    check("rst_halted", halted, 1);
    check("rst_pc_en",  pc_en, 0);
    check("rst_count",  step_count, 0);
    reset = 1'b0;
    cyc(2);

    // Run mode: pulses on RUN cycles 4, 8, 12.
    start = 1'b1; run_mode = 1'b1;
    cyc(1);
    start = 1'b0;
    check("run_enter", state, 1);
    cyc(4);
    check("run_p1", pc_en, 1);
    check("run_c1", step_count, 1);
    cyc(4);
    check("run_p2", pc_en, 1);
    cyc(4);
    check("run_p3", pc_en, 1);
    check("run_c3", step_count, 3);
    check("run_running", running, 1);

    // Ecall the cycle after a pulse; hold 50 cycles; ack releases it.
    cyc(1);
    ecall = 1'b1;
    cyc(1);
    check("ec_state", state, 3);
    check("ec_hold",  ecall_hold, 1);
    check("ec_pc_en", pc_en, 0);
    cyc(50);
    check("ec_frozen_count", step_count, 3);
    check("ec_frozen_state", state, 3);
    ecall_ack = 1'b1;
    cyc(1);
    check("ack_pc_en", pc_en, 1);
    check("ack_state", state, 1);
    check("ack_hold",  ecall_hold, 0);
    check("ack_count", step_count, 4);
    cyc(1);  // ecall still high during the pc_en cycle: must be ignored
    check("ack_no_retrap", state, 1);
    ecall = 1'b0; ecall_ack = 1'b0;
    cyc(2);
    check("ack_next_p_early", pc_en, 0);
    cyc(1);
    check("ack_next_p", pc_en, 1);
    check("ack_next_c", step_count, 5);

    // Halt colliding with terminal divide count and ecall.
    cyc(3);
    halt = 1'b1; ecall = 1'b1;
    cyc(1);
    check("halt_state",  state, 0);
    check("halt_halted", halted, 1);
    check("halt_pc_en",  pc_en, 0);
    check("halt_hold",   ecall_hold, 0);
    check("halt_count",  step_count, 5);
    halt = 1'b0; ecall = 1'b0;

    // Mode toggle mid-divide, then back to run.
    start = 1'b1; run_mode = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    run_mode = 1'b0;
    cyc(1);
    check("tog_step",  state, 2);
    check("tog_pc_en", pc_en, 0);
    cyc(3);
    check("tog_count", step_count, 5);
    run_mode = 1'b1;
    cyc(4);
    check("tog_run_early", pc_en, 0);
    cyc(1);
    check("tog_run_p", pc_en, 1);
    check("tog_run_c", step_count, 6);

    // Step mode: bouncy press, long hold, release.
    run_mode = 1'b0;
    cyc(1);
    check("step_state", state, 2);
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1;
    pulses = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (pc_en) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("press_one_pulse", pulses, 1);
    check("press_latency_ok", (first > 0) && (first <= DB_CYCLES + 4), 1);
    check("press_count", step_count, 7);
    step_btn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (pc_en) pulses++;
    end
    check("release_no_pulse", pulses, 0);
    check("release_count", step_count, 7);

    // Async reset in ECALL with the release pulse pending.
    ecall = 1'b1;
    cyc(1);
    check("ar_in_ecall", state, 3);
    ecall_ack = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("ar_state",  state, 0);
    check("ar_halted", halted, 1);
    check("ar_hold",   ecall_hold, 0);
    check("ar_pc_en",  pc_en, 0);
    check("ar_count",  step_count, 0);
    check("ar_running", running, 0);
    cyc(2);
    ecall = 1'b0; ecall_ack = 1'b0;
    reset = 1'b0;
    cyc(2);
    check("post_ar_state", state, 0);
    check("post_ar_count", step_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
